dm_access_unit: RTL and testbench
=================================

// Module: dm_access_unit
// PURPOSE
//   Load/store sequencer between the CPU execute stage and the 256x8 data memory DM.
//   Accepts one memory request per valid/ready handshake and computes the effective address.
//   Drives DM's wrt_en/address/wrt_data, captures DM's rd_data, and returns a result via valid/ready.
//   Supports LOAD, STORE and atomic SWAP (read old value, then write new value), plus saturating op counters.
// PARAMETERS
//   ADDR_W  8   DM address width; effective address wraps modulo 2**ADDR_W
//   DATA_W  8   DM data width
//   CNT_W   16  width of the saturating load/store statistics counters
// PORTS
//   CLK          in   1       system clock; all state updates on its rising edge
//   RST_N        in   1       asynchronous, active-low reset
//   req_valid    in   1       request present
//   req_ready    out  1       unit can accept a request (high only in IDLE)
//   req_op       in   2       00=LOAD 01=STORE 10=SWAP 11=illegal
//   req_base     in   ADDR_W  base address
//   req_offset   in   ADDR_W  two's-complement offset added to req_base
//   req_wdata    in   DATA_W  store/swap data
//   resp_valid   out  1       result present; held until resp_ready
//   resp_ready   in   1       consumer accepts result
//   resp_rdata   out  DATA_W  loaded/old value; 0 for STORE and illegal ops
//   resp_err     out  1       1 = illegal op (no DM access was made)
//   dm_wrt_en    out  1       to DM wrt_en
//   dm_address   out  ADDR_W  to DM address
//   dm_wrt_data  out  DATA_W  to DM wrt_data
//   dm_rd_data   in   DATA_W  from DM rd_data (combinational read; reads 0 while wrt_en=1)
//   cnt_load     out  CNT_W   completed LOADs plus completed SWAPs; saturates at all-ones
//   cnt_store    out  CNT_W   completed STOREs plus completed SWAPs; saturates at all-ones
// BEHAVIOUR
//   FSM states: IDLE, RD, WR, RESP; reset state is IDLE.
//   Reset values: all registers 0; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0;
//     dm_wrt_en=0; dm_address=0; dm_wrt_data=0; counters=0.
//   Accept: in IDLE, on req_valid&&req_ready, latch op, addr=(req_base+req_offset) mod 2**ADDR_W, and wdata.
//     Next state: LOAD->RD, STORE->WR, SWAP->RD, illegal->RESP with resp_err=1.
//   RD, one cycle: dm_wrt_en=0, dm_address=addr; dm_rd_data is registered into rdata at the cycle end.
//     Next state: LOAD->RESP, SWAP->WR.
//   WR, exactly one cycle: dm_wrt_en=1, dm_address=addr, dm_wrt_data=wdata; DM writes on that edge. Next: RESP.
//   RESP: resp_valid=1; resp_rdata and resp_err stay stable until resp_ready. On resp_ready -> IDLE.
//     The next request can be accepted no earlier than the cycle after IDLE is re-entered.
//   Outside RD/WR: dm_wrt_en=0, and dm_address/dm_wrt_data are 0.
//   dm_* outputs are decoded only from registered state and latches; there is no combinational path from req_*.
//   Latency with resp_ready held high, accept at edge N:
//     LOAD and STORE: resp_valid at N+2.
//     SWAP: resp_valid at N+3.
//     Illegal op: resp_valid at N+1.
//   Counters increment when the access cycle completes (leaving RD for LOAD, leaving WR for STORE/SWAP),
//     not at the response; they never wrap.
//   Wrap-around: base=0xFF with offset=0x02 gives addr=0x01; base=0x00 with offset=0xFF gives addr=0xFF.
//   Reset mid-operation: FSM returns to IDLE at once and dm_wrt_en drops asynchronously.
//     A pending write is not performed; a SWAP reset in RD leaves memory unchanged.
//   req_* inputs are ignored outside IDLE; there is no request queueing.
// TESTING
//   LOAD base=0x10 off=0x05, DM[0x15]=0x15 -> dm_wrt_en=0 in RD; resp_rdata=0x15 at N+2; cnt_load=1.
//   STORE base=0x20 off=0x00 wdata=0xA5 -> dm_wrt_en high one cycle, addr 0x20; then LOAD 0x20 returns 0xA5.
//   SWAP addr 0x07 (holds 0x07) wdata=0x3C -> resp_rdata=0x07 at N+3; next LOAD 0x07 returns 0x3C.
//   Wrap: base=0xFF off=0x02 -> dm_address=0x01; base=0x00 off=0xFF -> dm_address=0xFF.
//   Illegal op=11 -> resp_err=1, resp_rdata=0, resp_valid at N+1, dm_wrt_en never asserted, counters unchanged.
//   Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0. Assert RST_N=0 during a STORE's WR
//     -> dm_wrt_en drops at once and the memory word is unchanged.

Source files
------------

// File: rtl/dm_access_unit_if.sv
// Request/response handshake bundle between the execute stage and the load/store unit.
interface dm_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_base, req_offset, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_base, req_offset, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_access_unit.sv
// Load/store/swap sequencer in front of a single-port data memory, with saturating op counters.
module dm_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  dm_access_unit_if.slave    bus,
  output logic               dm_wrt_en,
  output logic [ADDR_W-1:0]  dm_address,
  output logic [DATA_W-1:0]  dm_wrt_data,
  input  logic [DATA_W-1:0]  dm_rd_data,
  output logic [CNT_W-1:0]   cnt_load,
  output logic [CNT_W-1:0]   cnt_store
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              wrt_en_q, wrt_en_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [CNT_W-1:0]  cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0]  cnt_store_q, cnt_store_d;
  logic [ADDR_W-1:0] eff_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign eff_addr = bus.req_base + bus.req_offset;

  // DM drive values are precomputed for the state being entered, so dm_* come straight from flops.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wrt_en_d     = 1'b0;
    dm_addr_d    = '0;
    dm_wdata_d   = '0;
    cnt_load_d   = cnt_load_q;
    cnt_store_d  = cnt_store_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d         = bus.req_op;
          addr_d       = eff_addr;
          wdata_d      = bus.req_wdata;
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          case (bus.req_op)
            OP_LOAD, OP_SWAP: begin
              state_d   = RD;
              dm_addr_d = eff_addr;
            end
            OP_STORE: begin
              state_d    = WR;
              wrt_en_d   = 1'b1;
              dm_addr_d  = eff_addr;
              dm_wdata_d = bus.req_wdata;
            end
            default: begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
            end
          endcase
        end
      end
      RD: begin
        resp_rdata_d = dm_rd_data;
        if (op_q == OP_SWAP) begin
          state_d    = WR;
          wrt_en_d   = 1'b1;
          dm_addr_d  = addr_q;
          dm_wdata_d = wdata_q;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          cnt_load_d   = sat_inc(cnt_load_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        cnt_store_d  = sat_inc(cnt_store_q);
        if (op_q == OP_SWAP) cnt_load_d = sat_inc(cnt_load_q);
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset clears wrt_en_q immediately, so an in-flight write never reaches DM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wrt_en_q     <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      cnt_load_q   <= '0;
      cnt_store_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wrt_en_q     <= wrt_en_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      cnt_load_q   <= cnt_load_d;
      cnt_store_q  <= cnt_store_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dm_wrt_en      = wrt_en_q;
  assign dm_address     = dm_addr_q;
  assign dm_wrt_data    = dm_wdata_q;
  assign cnt_load       = cnt_load_q;
  assign cnt_store      = cnt_store_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural 256x8 DM initialised to mem[i]=i.
module tb_dm_access_unit;
  logic        CLK;
  logic        RST_N;
  logic        dm_wrt_en;
  logic [7:0]  dm_address;
  logic [7:0]  dm_wrt_data;
  logic [7:0]  dm_rd_data;
  logic [15:0] cnt_load;
  logic [15:0] cnt_store;

  int tests = 0;
  int fails = 0;

  dm_access_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dm_access_unit #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .dm_wrt_en   (dm_wrt_en),
    .dm_address  (dm_address),
    .dm_wrt_data (dm_wrt_data),
    .dm_rd_data  (dm_rd_data),
    .cnt_load    (cnt_load),
    .cnt_store   (cnt_store)
  );

  logic [7:0] mem [256];
  logic       mem_rdy = 1'b0;

  always @(posedge CLK) begin
    if (!mem_rdy) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_rdy <= 1'b1;
    end else if (dm_wrt_en) begin
      mem[dm_address] <= dm_wrt_data;
    end
  end

  assign dm_rd_data = dm_wrt_en ? 8'h00 : mem[dm_address];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, returns latency to resp_valid, address seen in the first cycle after
  // acceptance, and the number of sampled cycles with dm_wrt_en high.
  task automatic issue(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                       input logic [7:0] wd, output int lat, output logic [7:0] a1,
                       output int wrc);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wd;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    a1  = dm_address;
    wrc = int'(dm_wrt_en);
    while (!bus.resp_valid && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
      wrc += int'(dm_wrt_en);
    end
  endtask

  task automatic consume();
    @(posedge CLK); #1;
  endtask

  int         lat, wrc;
  logic [7:0] a1;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_base   = 8'h00;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'h00;
    bus.resp_ready = 1'b1;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready",  bus.req_ready,  1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err",   bus.resp_err,   0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_wrt_en",     dm_wrt_en,      0);
    check("rst_address",    dm_address,     0);
    check("rst_wrt_data",   dm_wrt_data,    0);
    check("rst_cnt_load",   cnt_load,       0);
    check("rst_cnt_store",  cnt_store,      0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    issue(2'b00, 8'h10, 8'h05, 8'h00, lat, a1, wrc);
    check("load_lat",   lat, 2);
    check("load_addr",  a1, 8'h15);
    check("load_wr",    wrc, 0);
    check("load_rdata", bus.resp_rdata, 8'h15);
    check("load_err",   bus.resp_err, 0);
    check("load_cnt",   cnt_load, 1);
    consume();
    check("load_ready_back", bus.req_ready, 1);
    check("load_valid_drop", bus.resp_valid, 0);

    issue(2'b01, 8'h20, 8'h00, 8'hA5, lat, a1, wrc);
    check("store_lat",   lat, 2);
    check("store_addr",  a1, 8'h20);
    check("store_wr",    wrc, 1);
    check("store_rdata", bus.resp_rdata, 0);
    check("store_cnt",   cnt_store, 1);
    check("store_mem",   mem[8'h20], 8'hA5);
    consume();

    issue(2'b00, 8'h20, 8'h00, 8'h00, lat, a1, wrc);
    check("reload_rdata", bus.resp_rdata, 8'hA5);
    consume();

    issue(2'b10, 8'h07, 8'h00, 8'h3C, lat, a1, wrc);
    check("swap_lat",   lat, 3);
    check("swap_wr",    wrc, 1);
    check("swap_rdata", bus.resp_rdata, 8'h07);
    check("swap_cnt_ld", cnt_load, 3);
    check("swap_cnt_st", cnt_store, 2);
    consume();

    issue(2'b00, 8'h07, 8'h00, 8'h00, lat, a1, wrc);
    check("swap_reload", bus.resp_rdata, 8'h3C);
    consume();

    issue(2'b00, 8'hFF, 8'h02, 8'h00, lat, a1, wrc);
    check("wrap_hi_addr",  a1, 8'h01);
    check("wrap_hi_rdata", bus.resp_rdata, 8'h01);
    consume();

    issue(2'b00, 8'h00, 8'hFF, 8'h00, lat, a1, wrc);
    check("wrap_neg_addr",  a1, 8'hFF);
    check("wrap_neg_rdata", bus.resp_rdata, 8'hFF);
    consume();

    issue(2'b00, 8'h10, 8'hFE, 8'h00, lat, a1, wrc);
    check("negoff_addr", a1, 8'h0E);
    check("cnt_load_7",  cnt_load, 7);
    consume();

    issue(2'b11, 8'h40, 8'h00, 8'h99, lat, a1, wrc);
    check("ill_lat",    lat, 1);
    check("ill_err",    bus.resp_err, 1);
    check("ill_rdata",  bus.resp_rdata, 0);
    check("ill_wr",     wrc, 0);
    check("ill_cnt_ld", cnt_load, 7);
    check("ill_cnt_st", cnt_store, 2);
    consume();

    // Held response: a competing store must be ignored while the unit waits for resp_ready.
    bus.resp_ready = 1'b0;
    issue(2'b00, 8'h33, 8'h00, 8'h00, lat, a1, wrc);
    check("hold_lat", lat, 2);
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b01;
    bus.req_base   = 8'h33;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", bus.resp_valid, 1);
      check("hold_rdata", bus.resp_rdata, 8'h33);
      check("hold_ready", bus.req_ready, 0);
      check("hold_wr",    dm_wrt_en, 0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    consume();
    check("hold_release", bus.req_ready, 1);
    check("hold_mem",     mem[8'h33], 8'h33);
    check("hold_cnt_st",  cnt_store, 2);

    // Reset in the middle of a STORE's write cycle.
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b01;
    bus.req_base   = 8'h30;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'h77;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    check("rstwr_pre_en", dm_wrt_en, 1);
    #2 RST_N = 1'b0;
    #1;
    check("rstwr_async_drop", dm_wrt_en, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check("rstwr_mem",      mem[8'h30], 8'h30);
    check("rstwr_ready",    bus.req_ready, 1);
    check("rstwr_valid",    bus.resp_valid, 0);
    check("rstwr_cnt_st",   cnt_store, 0);
    @(posedge CLK); #1;

    issue(2'b00, 8'h30, 8'h00, 8'h00, lat, a1, wrc);
    check("post_rst_load", bus.resp_rdata, 8'h30);
    check("post_rst_cnt",  cnt_load, 1);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
